// File: rtl/perspective_transform_arbiter_if.sv
// Requester and result bus of the perspective transform arbiter.
// The arbiter connects through the slave modport; the requester side
// (or a bench standing in for it) connects through the master modport.
interface perspective_transform_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*11-1:0] req_x;
  logic [N_REQ*11-1:0] req_y;
  logic [N_REQ-1:0]    req_ready;
  logic                res_valid;
  logic [2:0]          res_id;
  logic [10:0]         res_x;
  logic [10:0]         res_y;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, res_valid, res_id, res_x, res_y
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, res_valid, res_id, res_x, res_y
  );
endinterface

// File: rtl/perspective_transform_arbiter.sv
// Shares one fixed-latency perspective transform datapath between N_REQ
// requesters. A tag pipeline (valid + id) runs alongside the datapath so
// each transformed result is returned with the id of its owner.
// Build option: define PT_ARB_FIXED_PRIO_EN for fixed priority (lowest
// valid index wins); otherwise grants rotate round-robin.
module perspective_transform_arbiter #(
  parameter int N_REQ      = 4,
  parameter int PT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  perspective_transform_arbiter_if.slave bus,
  output logic [10:0] pt_x_coord,
  output logic [10:0] pt_y_coord,
  input  logic [10:0] pt_x_adj,
  input  logic [10:0] pt_y_adj,
  output logic [4:0]  inflight,
  output logic        idle
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int DEPTH = PT_LATENCY + 1;

  logic [10:0]      w_x [N_REQ];
  logic [10:0]      w_y [N_REQ];
  logic             w_grant_any;
  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_cand;

  logic [10:0]      r_pt_x;
  logic [10:0]      r_pt_y;
  logic [DEPTH-1:0] r_tag_vld;
  logic [2:0]       r_tag_id [DEPTH];
  logic             r_res_valid;
  logic [2:0]       r_res_id;
  logic [10:0]      r_res_x;
  logic [10:0]      r_res_y;
  logic [4:0]       r_inflight;

  // Unpack the flat coordinate buses so the grant index selects directly.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_x[g] = bus.req_x[11*g +: 11];
    assign w_y[g] = bus.req_y[11*g +: 11];
  end

`ifdef PT_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'(i);
      if (bus.req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (!enable || !rst_n) w_grant_any = 1'b0;
  end
`else
  logic [IDX_W-1:0] r_last_grant;

  // Round-robin: scan offsets from far to near so the requester just after
  // the last grant is written last and therefore wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      w_cand = IDX_W'((int'(r_last_grant) + off) % N_REQ);
      if (bus.req_valid[w_cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
    if (!enable || !rst_n) w_grant_any = 1'b0;
  end

  // Priority pointer moves only when a transfer actually happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_last_grant <= IDX_W'(N_REQ - 1);
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    else if (w_grant_any) r_last_grant <= w_grant_idx;
  end
`endif

  assign bus.req_ready = w_grant_any ? (N_REQ'(1) << w_grant_idx) : '0;

  // Launch the granted coordinates into the datapath; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pt_x <= '0;
      r_pt_y <= '0;
    end else if (w_grant_any) begin
      r_pt_x <= w_x[w_grant_idx];
      r_pt_y <= w_y[w_grant_idx];
    end
  end

  // Tag pipeline mirroring the datapath latency plus the launch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag array is reset because stale tags would emit phantom results after reset.
      r_tag_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[DEPTH-2:0], w_grant_any};
      r_tag_id[0] <= 3'(w_grant_idx);
      for (int k = 1; k < DEPTH; k++) r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  // Capture the transformed result when the matching tag reaches the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_x     <= '0;
      r_res_y     <= '0;
    end else begin
      r_res_valid <= r_tag_vld[DEPTH-1];
      if (r_tag_vld[DEPTH-1]) begin
        r_res_id <= r_tag_id[DEPTH-1];
        r_res_x  <= pt_x_adj;
        r_res_y  <= pt_y_adj;
      end
    end
  end

  // Count transfers accepted but not yet returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_grant_any, r_res_valid})
        2'b10:   r_inflight <= r_inflight + 5'd1;
        2'b01:   r_inflight <= r_inflight - 5'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign pt_x_coord    = r_pt_x;
  assign pt_y_coord    = r_pt_y;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_x     = r_res_x;
  assign bus.res_y     = r_res_y;
  assign inflight      = r_inflight;
  assign idle          = (r_inflight == 5'd0) && !(|bus.req_valid);
endmodule

// File: tb/tb_perspective_transform_arbiter.sv
// Directed bench for perspective_transform_arbiter (N_REQ=4, PT_LATENCY=3).
// A grant table drives the arbiter; a scoreboard of expected results with
// their due cycle is checked every cycle against the result bus and a
// reference inflight count. Hand sequences cover saturation, enable drain
// and mid-operation reset. Define PT_ARB_FIXED_PRIO_EN for both DUT and
// bench to exercise the fixed-priority build.
module tb_perspective_transform_arbiter;
  localparam int N_REQ  = 4;
  localparam int PT_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [10:0] pt_x_coord, pt_y_coord, pt_x_adj, pt_y_adj;
  logic [4:0]  inflight;
  logic        idle;

  perspective_transform_arbiter_if #(.N_REQ(N_REQ)) bus ();

  perspective_transform_arbiter #(.N_REQ(N_REQ), .PT_LATENCY(PT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .pt_x_coord(pt_x_coord), .pt_y_coord(pt_y_coord),
    .pt_x_adj(pt_x_adj), .pt_y_adj(pt_y_adj),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Datapath model: PT_LAT register stages, then a simple transform.
  function automatic logic [10:0] fx(input logic [10:0] x); return x + 11'd5;    endfunction
  function automatic logic [10:0] fy(input logic [10:0] y); return y ^ 11'h155; endfunction

  logic [10:0] dp_x [PT_LAT];
  logic [10:0] dp_y [PT_LAT];
  always @(posedge clk) begin
    dp_x[0] <= pt_x_coord;
    dp_y[0] <= pt_y_coord;
    for (int k = 1; k < PT_LAT; k++) begin
      dp_x[k] <= dp_x[k-1];
      dp_y[k] <= dp_y[k-1];
    end
  end
  assign pt_x_adj = fx(dp_x[PT_LAT-1]);
  assign pt_y_adj = fy(dp_y[PT_LAT-1]);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    logic [2:0]  id;
    logic [10:0] x;
    logic [10:0] y;
  } sb_t;
  sb_t sb[$];

  logic [10:0] base_x [N_REQ];
  logic [10:0] base_y [N_REQ];
  logic        xfer_now    = 1'b0;
  int          model_infl  = 0;
  logic [2:0]  last_id     = '0;
  logic [10:0] last_x      = '0;
  logic [10:0] last_y      = '0;

  // One cycle of stimulus: apply inputs, check the combinational grant, and
  // record the expected result of any transfer.
  task automatic drive_cycle(input logic en, input logic [3:0] valid, input logic [3:0] exp);
    sb_t e;
    @(posedge clk); #1;
    enable        = en;
    bus.req_valid = valid;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_x[11*i +: 11] = base_x[i];
      bus.req_y[11*i +: 11] = base_y[i];
    end
    xfer_now = (exp != 4'b0000);
    if (xfer_now) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (exp[i]) begin
          e.due = cyc + PT_LAT + 2;
          e.id  = 3'(i);
          e.x   = fx(base_x[i]);
          e.y   = fy(base_y[i]);
          sb.push_back(e);
          base_x[i] = base_x[i] + 11'd13;
          base_y[i] = base_y[i] + 11'd29;
        end
      end
    end
    #1;
    check("req_ready", bus.req_ready, exp);
  endtask

  // Every cycle out of reset: exact result timing/content, hold of result
  // fields between strobes, and the inflight count.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic dec;
      dec = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("res_valid_hi", bus.res_valid, 1);
        check("res_id", bus.res_id, sb[0].id);
        check("res_x", bus.res_x, sb[0].x);
        check("res_y", bus.res_y, sb[0].y);
        last_id = sb[0].id;
        last_x  = sb[0].x;
        last_y  = sb[0].y;
        void'(sb.pop_front());
        dec = 1'b1;
      end else begin
        check("res_valid_lo", bus.res_valid, 0);
        check("res_hold_id", bus.res_id, last_id);
        check("res_hold_x", bus.res_x, last_x);
        check("res_hold_y", bus.res_y, last_y);
      end
      check("inflight", inflight, model_infl);
      model_infl = model_infl + int'(xfer_now) - int'(dec);
    end
  end

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] exp_rr;
    logic [3:0] exp_fp;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    // {enable, req_valid, expected round-robin grant, expected fixed-priority grant}
    vecs[0] = '{1'b1, 4'b0100, 4'b0100, 4'b0100};
    vecs[1] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{1'b0, 4'b1111, 4'b0000, 4'b0000};
    vecs[3] = '{1'b1, 4'b1111, 4'b1000, 4'b0001};
    vecs[4] = '{1'b1, 4'b1111, 4'b0001, 4'b0001};
    vecs[5] = '{1'b1, 4'b0101, 4'b0100, 4'b0001};
    vecs[6] = '{1'b1, 4'b0101, 4'b0001, 4'b0001};
    vecs[7] = '{1'b1, 4'b1001, 4'b1000, 4'b0001};
    vecs[8] = '{1'b1, 4'b0010, 4'b0010, 4'b0010};
    vecs[9] = '{1'b1, 4'b0010, 4'b0010, 4'b0010};

    base_x[0] = 11'd10;  base_y[0] = 11'd2040;
    base_x[1] = 11'd55;  base_y[1] = 11'd3;
    base_x[2] = 11'd100; base_y[2] = 11'd200;
    base_x[3] = 11'd700; base_y[3] = 11'd1000;

    // Reset state, with requests present to show grants are suppressed.
    rst_n = 1'b0; enable = 1'b1;
    bus.req_valid = 4'b1111; bus.req_x = '0; bus.req_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_res_x", bus.res_x, 0);
    check("rst_res_y", bus.res_y, 0);
    check("rst_pt_x", pt_x_coord, 0);
    check("rst_pt_y", pt_y_coord, 0);
    check("rst_inflight", inflight, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b0; bus.req_valid = '0;

    // Table: first row is the single request from requester 2 (x=100, y=200).
    for (int v = 0; v < 10; v++) begin
`ifdef PT_ARB_FIXED_PRIO_EN
      e = vecs[v].exp_fp;
`else
      e = vecs[v].exp_rr;
`endif
      drive_cycle(vecs[v].en, vecs[v].valid, e);
    end
    repeat (7) drive_cycle(1'b1, 4'b0000, 4'b0000);
    check("idle_after_table", idle, 1);

    // Continuous requests: one grant per cycle, inflight saturates at PT_LAT+2.
    for (int k = 0; k < 12; k++) begin
`ifdef PT_ARB_FIXED_PRIO_EN
      drive_cycle(1'b1, 4'b1001, 4'b0001);
`else
      drive_cycle(1'b1, 4'b1111, 4'(1 << ((2 + k) % 4)));
`endif
    end
    check("inflight_sat", inflight, PT_LAT + 2);
    repeat (7) drive_cycle(1'b1, 4'b0000, 4'b0000);

    // Three transfers, then enable low with requests still pending.
`ifdef PT_ARB_FIXED_PRIO_EN
    repeat (3) drive_cycle(1'b1, 4'b0111, 4'b0001);
`else
    drive_cycle(1'b1, 4'b0111, 4'b0100);
    drive_cycle(1'b1, 4'b0111, 4'b0001);
    drive_cycle(1'b1, 4'b0111, 4'b0010);
`endif
    repeat (7) drive_cycle(1'b0, 4'b0111, 4'b0000);
    check("drain_inflight", inflight, 0);
    check("drain_idle_busy", idle, 0);
    drive_cycle(1'b0, 4'b0000, 4'b0000);
    check("drain_idle", idle, 1);

    // Two transfers in flight, then a one-cycle reset pulse.
`ifdef PT_ARB_FIXED_PRIO_EN
    drive_cycle(1'b1, 4'b1100, 4'b0100);
    drive_cycle(1'b1, 4'b1100, 4'b0100);
`else
    drive_cycle(1'b1, 4'b1100, 4'b0100);
    drive_cycle(1'b1, 4'b1100, 4'b1000);
`endif
    @(posedge clk); #1;
    rst_n = 1'b0; bus.req_valid = '0; xfer_now = 1'b0;
    sb.delete(); model_infl = 0;
    last_id = '0; last_x = '0; last_y = '0;
    #1;
    check("midrst_inflight", inflight, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(1'b1, 4'b1111, 4'b0001);
    repeat (8) drive_cycle(1'b1, 4'b0000, 4'b0000);
    check("final_inflight", inflight, 0);
    check("final_idle", idle, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/perspective_transform_arbiter.md
PERSPECTIVE_TRANSFORM_ARBITER -- requirements
Module: perspective_transform_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one perspective transform datapath (2..8).
REQ-002 Parameter PT_LATENCY, default 3: cycles from pt_x_coord/pt_y_coord change to the matching pt_x_adj/pt_y_adj (1..16).
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port enable  input  1: high permits new grants; low drains in-flight work only.
REQ-006 Port req_valid  input  N_REQ: per-requester coordinate pending.
REQ-007 Port req_x  input  N_REQ*11: packed raw x coordinates, requester i at bits [11i+10:11i].
REQ-008 Port req_y  input  N_REQ*11: packed raw y coordinates, same packing.
REQ-009 Port req_ready  output  N_REQ: one-hot-or-zero grant; transfer when req_valid[i] and req_ready[i].
REQ-010 Port pt_x_coord  output  11: registered x to datapath.
REQ-011 Port pt_y_coord  output  11: registered y to datapath.
REQ-012 Port pt_x_adj  input  11: transformed x from datapath.
REQ-013 Port pt_y_adj  input  11: transformed y from datapath.
REQ-014 Port res_valid  output  1: one-cycle result strobe, no backpressure.
REQ-015 Port res_id  output  3: index of requester owning the result.
REQ-016 Port res_x  output  11: registered copy of pt_x_adj for that result.
REQ-017 Port res_y  output  11: registered copy of pt_y_adj for that result.
REQ-018 Port inflight  output  5: number of accepted transfers not yet returned.
REQ-019 Port idle  output  1: high when inflight is 0 and no req_valid bit is set.

Function
REQ-020 req_ready SHALL be combinational from req_valid, enable and the priority pointer; all-zero when enable low or no requester valid.
REQ-021 At most one transfer SHALL occur per cycle; requesters SHALL hold valid and data stable until their transfer.
REQ-022 Round-robin: search starts at index (last_grant+1) mod N_REQ; last_grant updates only on a transfer.
REQ-023 Transfer in cycle T: pt_x_coord/pt_y_coord load the granted coordinates at edge ending T; otherwise they hold their last value.
REQ-024 A tag pipeline (valid bit + 3-bit id) of depth PT_LATENCY+1 SHALL track each transfer in parallel with the datapath.
REQ-025 For a transfer in cycle T, res_valid SHALL be high in cycle T+PT_LATENCY+2 only, with res_id = granted index and res_x/res_y = pt_x_adj/pt_y_adj sampled in cycle T+PT_LATENCY+1.
REQ-026 res_x/res_y/res_id SHALL hold their last values while res_valid is low.
REQ-027 Back-to-back transfers SHALL produce back-to-back results in acceptance order; full throughput is one per cycle.
REQ-028 inflight SHALL increment on transfer, decrement on res_valid, remain unchanged when both coincide; maximum value PT_LATENCY+2.
REQ-029 enable deassertion SHALL block new grants the same cycle; in-flight results SHALL still be delivered.

Reset
REQ-030 On rst_n low: req_ready 0, res_valid 0, res_id 0, res_x 0, res_y 0, pt_x_coord 0, pt_y_coord 0, inflight 0, tag pipeline cleared, last_grant = N_REQ-1.
REQ-031 Reset mid-operation SHALL discard all in-flight tags; no res_valid SHALL occur for transfers accepted before reset.

Configuration
REQ-032 Macro PT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest valid index wins, last_grant unused.
REQ-033 Macro PT_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-022.

Verification
REQ-034 Single request: req 2 valid with x=100,y=200, enable=1 -> req_ready=4'b0100 same cycle; res_valid 5 cycles later (PT_LATENCY=3), res_id=2, res_x/res_y = datapath model outputs.
REQ-035 All four valid continuously -> grant order 0,1,2,3,0,... one per cycle; results arrive in same order; inflight saturates at 5.
REQ-036 With PT_ARB_FIXED_PRIO_EN, requesters 0 and 3 valid continuously -> requester 3 never granted.
REQ-037 Three transfers accepted, then enable=0 -> no further req_ready; three res_valid pulses; inflight returns 0; idle high once req_valid cleared.
REQ-038 Two transfers in flight, rst_n pulsed low 1 cycle -> no res_valid afterwards, inflight=0, first post-reset grant goes to requester 0.
